// File: rtl/prog_threshold_fifo.sv
// Single-clock FWFT FIFO with runtime almost-full/almost-empty thresholds and registered count.
// Define PROG_THRESHOLD_FIFO_ERR_FLAGS_EN to get sticky OVERFLOW/UNDERFLOW; otherwise they read 0.
module prog_threshold_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] DIN,
  input  logic             WE,
  input  logic             RE,
  output logic [WIDTH-1:0] DOUT,
  output logic             NOT_EMPTY,
  output logic             FULL,
  input  logic [AW:0]      AF_THRESH,
  input  logic [AW:0]      AE_THRESH,
  output logic             ALMOST_FULL,
  output logic             ALMOST_EMPTY,
  output logic [AW:0]      COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  localparam int          DEPTH_CHK = DEPTH;
  localparam logic [AW:0] FULL_CNT  = DEPTH_CHK[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wp_reg, rp_reg;
  logic [AW:0]      wp_next, rp_next, cnt_next;
  logic [AW:0]      count_reg;
  logic             not_empty_reg, full_reg;
  logic             almost_full_reg, almost_empty_reg;
  logic [WIDTH-1:0] ram_q_reg, byp_data_reg;
  logic             byp_reg;
  logic             clr, wr_ok, rd_ok, bypass;

  always_comb begin
    clr      = RESET | FLUSH;
    wr_ok    = WE & ~full_reg & ~clr;
    rd_ok    = RE & not_empty_reg & ~clr;
    wp_next  = wp_reg + {{AW{1'b0}}, wr_ok};
    rp_next  = rp_reg + {{AW{1'b0}}, rd_ok};
    cnt_next = wp_next - rp_next;
    // Queue is empty after this edge's pop, so the written word becomes the head.
    bypass   = wr_ok & (wp_reg[AW-1:0] == rp_next[AW-1:0]);
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      wp_reg           <= '0;
      rp_reg           <= '0;
      count_reg        <= '0;
      not_empty_reg    <= 1'b0;
      full_reg         <= 1'b0;
      almost_full_reg  <= (AF_THRESH == '0);
      almost_empty_reg <= 1'b1;
      byp_reg          <= 1'b0;
    end else begin
      wp_reg           <= wp_next;
      rp_reg           <= rp_next;
      count_reg        <= cnt_next;
      not_empty_reg    <= (cnt_next != '0);
      full_reg         <= (cnt_next == FULL_CNT);
      almost_full_reg  <= (cnt_next >= AF_THRESH);
      almost_empty_reg <= (cnt_next <= AE_THRESH);
      byp_reg          <= bypass;
    end
  end

  // Storage array with registered read; the read address is the post-pop head.
  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      mem[wp_reg[AW-1:0]] <= DIN;
    end
    ram_q_reg <= mem[rp_next[AW-1:0]];
  end

  always_ff @(posedge CLK) begin
    byp_data_reg <= DIN;
  end

  assign DOUT         = byp_reg ? byp_data_reg : ram_q_reg;
  assign NOT_EMPTY    = not_empty_reg;
  assign FULL         = full_reg;
  assign ALMOST_FULL  = almost_full_reg;
  assign ALMOST_EMPTY = almost_empty_reg;
  assign COUNT        = count_reg;

`ifdef PROG_THRESHOLD_FIFO_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (WE && full_reg) begin
        overflow_reg <= 1'b1;
      end
      if (RE && !not_empty_reg) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign OVERFLOW  = overflow_reg;
  assign UNDERFLOW = underflow_reg;
`else
  assign OVERFLOW  = 1'b0;
  assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_prog_threshold_fifo.sv
// Randomized and directed bench for prog_threshold_fifo, checked against a queue-based model.
module tb_prog_threshold_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

`ifdef PROG_THRESHOLD_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET = 1'b0, FLUSH = 1'b0, WE = 1'b0, RE = 1'b0;
  logic [WIDTH-1:0] DIN = '0;
  logic [WIDTH-1:0] DOUT;
  logic             NOT_EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [AW:0]      AF_THRESH = 6'd28, AE_THRESH = 6'd2;
  logic [AW:0]      COUNT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [WIDTH-1:0] q[$];
  bit               m_ovf, m_unf;

  prog_threshold_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .DIN(DIN), .WE(WE), .RE(RE),
    .DOUT(DOUT), .NOT_EMPTY(NOT_EMPTY), .FULL(FULL),
    .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check_val("count",        32'(COUNT),        32'(n));
    check_val("not_empty",    32'(NOT_EMPTY),    32'(n != 0));
    check_val("full",         32'(FULL),         32'(n == DEPTH));
    check_val("almost_full",  32'(ALMOST_FULL),  32'(n >= int'(AF_THRESH)));
    check_val("almost_empty", 32'(ALMOST_EMPTY), 32'(n <= int'(AE_THRESH)));
    check_val("overflow",     32'(OVERFLOW),     32'(m_ovf));
    check_val("underflow",    32'(UNDERFLOW),    32'(m_unf));
    if (n > 0) check_val("dout", 32'(DOUT), 32'(q[0]));
  endtask

  // Drive one cycle, advance the model at the edge, check at the following falling edge.
  task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d,
                      input bit f, input bit rs);
    bit was_full, was_empty;
    WE = w; RE = r; DIN = d; FLUSH = f; RESET = rs;
    @(posedge CLK);
    if (rs || f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (ERR_EN && w && was_full) m_ovf = 1'b1;
      if (ERR_EN && r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) void'(q.pop_front());
      if (w && !was_full) q.push_back(d);
    end
    @(negedge CLK);
    cyc++;
    $display("[TB] c=%0d rst=%0b fl=%0b we=%0b re=%0b din=%02h cnt=%0d ne=%0b dout=%02h",
             cyc, rs, f, w, r, d, COUNT, NOT_EMPTY, DOUT);
    check_all();
  endtask

  initial begin
    int wbias, rbias;
    @(negedge CLK);

    // Reset for two clocks
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);
    check_val("rst_count", 32'(COUNT), 32'd0);
    check_val("rst_ae", 32'(ALMOST_EMPTY), 32'd1);

    // Fill 0x00..0x1F then one rejected write
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 8'(i), 0, 0);
      if (i == 26) check_val("af_before_28", 32'(ALMOST_FULL), 32'd0);
      if (i == 27) check_val("af_at_28", 32'(ALMOST_FULL), 32'd1);
    end
    check_val("fill_full", 32'(FULL), 32'd1);
    step(1, 0, 8'hEE, 0, 0);
    check_val("fill_extra_count", 32'(COUNT), 32'd32);
    check_val("fill_overflow", 32'(OVERFLOW), 32'(ERR_EN));

    // Drain in order then one extra read
    for (int i = 0; i < DEPTH; i++) begin
      check_val("drain_order", 32'(DOUT), 32'(i));
      step(0, 1, 8'h00, 0, 0);
    end
    check_val("drain_empty", 32'(NOT_EMPTY), 32'd0);
    step(0, 1, 8'h00, 0, 0);
    check_val("drain_underflow", 32'(UNDERFLOW), 32'(ERR_EN));
    step(0, 0, 8'h00, 1, 0);

    // Bypass then sustained simultaneous traffic
    step(1, 0, 8'hA5, 0, 0);
    check_val("bypass_dout", 32'(DOUT), 32'hA5);
    for (int i = 0; i < 100; i++) step(1, 1, 8'(i), 0, 0);
    check_val("rw_count", 32'(COUNT), 32'd1);
    step(0, 1, 8'h00, 0, 0);

    // Full with simultaneous read/write
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
    step(1, 1, 8'h77, 0, 0);
    check_val("full_rw_count", 32'(COUNT), 32'd31);
    for (int i = 0; i < 31; i++) step(0, 1, 8'h00, 0, 0);

    // Flush mid-stream with a write that must be ignored
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h90 + i), 0, 0);
    step(1, 0, 8'hFF, 1, 0);
    check_val("flush_count", 32'(COUNT), 32'd0);
    step(1, 0, 8'h3C, 0, 0);
    check_val("flush_next", 32'(DOUT), 32'h3C);

    // Randomized traffic with moving thresholds
    wbias = 50; rbias = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        AF_THRESH = 6'($urandom_range(0, 40));
        AE_THRESH = 6'($urandom_range(0, 40));
        wbias     = int'($urandom_range(20, 80));
        rbias     = int'($urandom_range(20, 80));
      end
      step(($urandom_range(0, 99) < wbias), ($urandom_range(0, 99) < rbias),
           8'($urandom), ($urandom_range(0, 96) == 0), ($urandom_range(0, 210) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
